// File: rtl/ps2_tx_scheduler.sv
// Queues scan-code bytes and replays them as emulated PS/2 device frames with a fixed idle gap.
// Define PS2_TX_PARITY_EN to send real odd parity; otherwise the parity bit is sent as 0.
module ps2_tx_scheduler #(
    parameter int  DIVISOR    = 5000,
    parameter int  GAP_BITS   = 20,
    parameter int  FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [CW-1:0] o_count,
    output logic          o_ps2_clk,
    output logic          o_ps2_data,
    output logic          o_busy,
    output logic          o_done
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [31:0] HALF     = 32'(DIVISOR / 2);
    localparam logic [31:0] BIT_LAST = 32'(DIVISOR - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_BITS * DIVISOR - 1);
    localparam logic [3:0]  STOP_IDX = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIT,
        ST_GAP
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   cnt_reg, cnt_next;
    logic [3:0]    bit_idx_reg, bit_idx_next;
    logic [10:0]   shift_reg, shift_next;
    logic          ps2_clk_reg, ps2_clk_next;
    logic          ps2_data_reg, ps2_data_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push;
    logic          pop;
    logic [7:0]    head;
    logic          parity_bit;

    assign o_ready    = (count_reg != CW'(FIFO_DEPTH));
    assign o_count    = count_reg;
    assign o_ps2_clk  = ps2_clk_reg;
    assign o_ps2_data = ps2_data_reg;
    assign o_busy     = busy_reg;
    assign o_done     = done_reg;

    assign push = i_valid && o_ready;
    assign pop  = (state_reg == ST_LOAD);
    assign head = mem[rd_ptr_reg];

`ifdef PS2_TX_PARITY_EN
    assign parity_bit = ~(^head);
`else
    assign parity_bit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_next   = {1'b1, parity_bit, head, 1'b0};
                cnt_next     = '0;
                bit_idx_next = '0;
                state_next   = ST_BIT;
            end
            ST_BIT: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (bit_idx_reg == STOP_IDX) begin
                        state_next = ST_GAP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 4'd1;
                        shift_next   = {1'b1, shift_reg[10:1]};
                    end
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = '0;
                    // Pass straight to LOAD when work is waiting so back-to-back frames
                    // are spaced by the gap plus the single LOAD cycle, nothing more.
                    state_next = (count_reg != '0) ? ST_LOAD : ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they leave the fabric registered.
        ps2_clk_next  = 1'b1;
        ps2_data_next = 1'b1;
        if (state_next == ST_BIT) begin
            ps2_clk_next  = (cnt_next < HALF);
            ps2_data_next = shift_next[0];
        end
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_BIT) && (bit_idx_next == STOP_IDX) && (cnt_next == BIT_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '1;
            ps2_clk_reg  <= 1'b1;
            ps2_data_reg <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            ps2_clk_reg  <= ps2_clk_next;
            ps2_data_reg <= ps2_data_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

endmodule
